// File: rtl/imem_lock_loader_if.sv
// Valid/ready instruction-word stream that feeds the image loader.
// The source drives valid/data; the loader drives ready.
interface imem_lock_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/imem_lock_loader.sv
// Streams an instruction image into the key-locked instruction memory through a key-dependent mask,
// holding the core in reset until the whole image has been written.
module imem_lock_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    KEY_WIDTH  = 8,
  parameter logic [KEY_WIDTH-1:0]  KEY_VAL    = 8'hA5,
  parameter int                    NUM_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_WIDTH-1:0]  i_key,
  input  logic                  i_start,
  imem_lock_loader_if.slave     i_stream,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_core_hold
);

  localparam int                CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     LAST_IX = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A wrong key silently turns into a non-zero XOR pattern replicated across the word.
  function automatic logic [DATA_WIDTH-1:0] key_mask(input logic [KEY_WIDTH-1:0] k);
    key_mask = {(DATA_WIDTH / KEY_WIDTH){k ^ KEY_VAL}};
  endfunction

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic [KEY_WIDTH-1:0]  r_key_q;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_core_hold;
  logic                  w_ready;
  logic                  w_xfer;

  assign w_ready        = (r_state == S_LOAD);
  assign w_xfer         = w_ready & i_stream.valid;
  assign i_stream.ready = w_ready;

  // Loader FSM with registered memory-write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_key_q     <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_core_hold <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_key_q     <= i_key;
            r_count     <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_core_hold <= 1'b1;
          end else begin
            r_state <= r_state;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_waddr <= r_count[ADDR_WIDTH-1:0];
            r_wdata <= i_stream.data ^ key_mask(r_key_q);
            r_count <= r_count + CW'(1);
            // The final write pulse lands in the first DONE cycle.
            if (r_count == LAST_IX) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_core_hold <= 1'b0;
            end else begin
              r_state <= S_LOAD;
            end
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_core_hold <= 1'b1;
        end
      endcase
    end
  end

  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_core_hold = r_core_hold;

endmodule
